// File: rtl/sram_access_ctrl.sv
// SRAM initiator: valid/ready command port, one registered SRAM cycle per command,
// read data returned in order through a credit-protected response FIFO. Option: SRAM_INIT_EN.
module sram_access_ctrl #(
    parameter int              DW        = 140,
    parameter int              DD        = 1024,
    parameter int              AW        = 10,
    parameter int              RSP_DEPTH = 4,
    parameter logic [DW-1:0]   INIT_VAL  = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          sram_n_cs,
    output logic          sram_n_we,
    output logic          sram_n_oe,
    output logic [AW-1:0] sram_ad,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout,
    output logic          init_done
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic          run;
    logic          init_wr;
    logic          init_last;
    logic [AW-1:0] init_addr;
    logic          req_acc;
    logic          rd_acc;
    logic          push;
    logic          pop;
    logic [1:0]    rd_pipe;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] fifo_mem [RSP_DEPTH];

    assign req_ready = run && (outstanding < CW'(RSP_DEPTH));
    assign req_acc   = req_valid && req_ready;
    assign rd_acc    = req_acc && !req_we;
    assign init_done = run;
    assign init_last = (init_addr == AW'(DD - 1));

`ifdef SRAM_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        init_wr   = 1'b0;
        case (state)
            ST_INIT: begin
                init_wr = 1'b1;
                if (init_last) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign run = (state == ST_RUN);
`else
    assign init_wr = 1'b0;
    assign run     = 1'b1;
`endif

    // Sweep address; held at 0 whenever no sweep is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          init_addr <= '0;
        else if (init_wr) init_addr <= init_last ? '0 : init_addr + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_n_cs <= 1'b1;
            sram_n_we <= 1'b1;
            sram_ad   <= '0;
            sram_din  <= '0;
        end else if (init_wr) begin
            sram_n_cs <= 1'b0;
            sram_n_we <= 1'b0;
            sram_ad   <= init_addr;
            sram_din  <= INIT_VAL;
        end else if (req_acc) begin
            sram_n_cs <= 1'b0;
            sram_n_we <= !req_we;
            sram_ad   <= req_addr;
            if (req_we) sram_din <= req_wdata;
        end else begin
            sram_n_cs <= 1'b1;
            sram_n_we <= 1'b1;
        end
    end

    assign sram_n_oe = sram_n_cs;

    // rd_pipe[1] marks the cycle in which sram_dout carries data for a read.
    assign push      = rd_pipe[1];
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = (fifo_cnt != '0);
    assign rsp_rdata = fifo_mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: FIFO storage is not reset; fifo_cnt alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= sram_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
        end else begin
            rd_pipe     <= {rd_pipe[0], rd_acc};
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt    <= fifo_cnt + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(rd_acc) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: SRAM macro model, queue-based reference model checked
// every cycle, directed scenarios plus randomized traffic.
module tb_sram_access_ctrl;

    localparam int            DW        = 140;
    localparam int            AW        = 10;
    localparam int            DD        = 16;
    localparam int            RSP_DEPTH = 4;
    localparam logic [DW-1:0] INIT_VAL  = {{(DW-32){1'b0}}, 32'h5A5A_0F0F};
`ifdef SRAM_INIT_EN
    localparam int            INIT_CYC  = DD;
`else
    localparam int            INIT_CYC  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_n_cs, sram_n_we, sram_n_oe;
    logic [AW-1:0] sram_ad;
    logic [DW-1:0] sram_din, sram_dout;
    logic          init_done;

    int checks = 0;
    int errors = 0;

    sram_access_ctrl #(.DW(DW), .DD(DD), .AW(AW), .RSP_DEPTH(RSP_DEPTH), .INIT_VAL(INIT_VAL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sram_n_cs(sram_n_cs), .sram_n_we(sram_n_we), .sram_n_oe(sram_n_oe),
        .sram_ad(sram_ad), .sram_din(sram_din), .sram_dout(sram_dout),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int a);
        logic [DW-1:0] p;
        p = '0;
        p[31:0]  = 32'hC0DE_0000 | 32'(a);
        p[63:32] = ~32'(a);
        p[DW-1 -: 8] = 8'(a * 3);
        return p;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW; i++) w[i] = 1'($urandom_range(0, 1));
        return w;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous single-port SRAM; dout holds while deselected.
    logic [DW-1:0] sram_mem [2**AW];
    initial begin
        for (int a = 0; a < 2**AW; a++) sram_mem[a] = pat(a);
        forever begin
            @(posedge clk);
            if (!sram_n_cs) begin
                if (!sram_n_we) sram_mem[sram_ad] = sram_din;
                else            sram_dout <= sram_mem[sram_ad];
            end
        end
    end

    // Reference model: expected contents plus a queue of pending responses with due cycles.
    typedef struct {
        logic [DW-1:0] data;
        longint        due;
    } rsp_t;

    logic [DW-1:0] mdl_mem [2**AW];
    rsp_t          rq [$];
    longint        cyc = 0;
    bit            in_init = 1'b0;
    int            init_cnt = 0;
    logic          exp_n_cs = 1'b1, exp_n_we = 1'b1;
    logic [AW-1:0] exp_ad = '0;
    logic [DW-1:0] exp_din = '0;
    logic          exp_valid = 1'b0, exp_ready = 1'b0, exp_done = 1'b0;
    logic [DW-1:0] exp_rdata = '0;

    initial begin
        bit pre_valid, pre_ready;
        for (int a = 0; a < 2**AW; a++) mdl_mem[a] = pat(a);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                rq.delete();
                exp_n_cs = 1'b1;
                exp_n_we = 1'b1;
                exp_ad   = '0;
                exp_din  = '0;
                init_cnt = 0;
`ifdef SRAM_INIT_EN
                in_init = 1'b1;
                for (int a = 0; a < DD; a++) mdl_mem[a] = INIT_VAL;
`else
                in_init = 1'b0;
`endif
            end else begin
                pre_valid = (rq.size() > 0) && (rq[0].due <= cyc);
                pre_ready = !in_init && (rq.size() < RSP_DEPTH);
                cyc++;
                if (pre_valid && rsp_ready) void'(rq.pop_front());
                exp_n_cs = 1'b1;
                exp_n_we = 1'b1;
                if (in_init) begin
                    exp_n_cs = 1'b0;
                    exp_n_we = 1'b0;
                    exp_ad   = AW'(init_cnt);
                    exp_din  = INIT_VAL;
                    if (init_cnt == DD - 1) in_init = 1'b0;
                    init_cnt++;
                end else if (pre_ready && req_valid) begin
                    exp_n_cs = 1'b0;
                    exp_n_we = !req_we;
                    exp_ad   = req_addr;
                    if (req_we) begin
                        exp_din = req_wdata;
                        mdl_mem[req_addr] = req_wdata;
                    end else begin
                        rq.push_back('{data: mdl_mem[req_addr], due: cyc + 2});
                    end
                end
            end
            exp_valid = (rq.size() > 0) && (rq[0].due <= cyc);
            exp_rdata = (rq.size() > 0) ? rq[0].data : '0;
            exp_ready = !in_init && (rq.size() < RSP_DEPTH);
            exp_done  = !in_init;
        end
    end

    // Per-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid", rsp_valid, exp_valid);
            check("init_done", init_done, exp_done);
            check("sram_n_cs", sram_n_cs, exp_n_cs);
            check("sram_n_oe", sram_n_oe, exp_n_cs);
            check("sram_n_we", sram_n_we, exp_n_we);
            check("sram_ad",   sram_ad,   exp_ad);
            if (!exp_n_cs && !exp_n_we) check("sram_din", sram_din, exp_din);
            if (exp_valid) check("rsp_rdata", rsp_rdata, exp_rdata);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int k = 0;
        while (!init_done && k < DD + 20) begin
            cycle();
            k++;
        end
        check({name, "_init_cycles"}, 32'(k), 32'(INIT_CYC));
        check({name, "_init_done"}, init_done, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_n_cs", sram_n_cs, 1'b1);
        check("reset_n_we", sram_n_we, 1'b1);
        check("reset_n_oe", sram_n_oe, 1'b1);
        check("reset_ad", sram_ad, '0);
        check("reset_din", sram_din, '0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        rst = 1'b0;
        wait_init("boot");

        // Write then read the same address on the next cycle.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd5; req_wdata = 'hA5;
        cycle();
        req_we = 1'b0;
        cycle();
        idle();
        cycle();
        check("t1_valid_early", rsp_valid, 1'b0);
        cycle();
        check("t1_valid", rsp_valid, 1'b1);
        check("t1_rdata", rsp_rdata, 'hA5);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        check("t1_popped", rsp_valid, 1'b0);

        // Fill the credit window with reads, then drain in order.
        req_valid = 1'b1; req_we = 1'b0;
        for (int a = 1; a <= 4; a++) begin
            req_addr = AW'(a);
            cycle();
        end
        check("t2_ready_full", req_ready, 1'b0);
        req_addr = 10'd5;
        cycle();
        idle();
        cycle();
        rsp_ready = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            check("t2_order_valid", rsp_valid, 1'b1);
            check("t2_order_data", rsp_rdata, pat(a));
            cycle();
        end
        rsp_ready = 1'b0;
        check("t2_empty", rsp_valid, 1'b0);
        check("t2_ready_back", req_ready, 1'b1);

        // Continuous reads with a toggling consumer.
        for (int i = 0; i < 24; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i % 16);
            rsp_ready = i[0];
            cycle();
        end
        idle();
        rsp_ready = 1'b1;
        repeat (8) cycle();

        // Reset with two reads in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd7;
        cycle();
        req_addr = 10'd8;
        cycle();
        idle();
        rst = 1'b1;
        #1;
        check("t4_n_cs", sram_n_cs, 1'b1);
        check("t4_n_we", sram_n_we, 1'b1);
        check("t4_n_oe", sram_n_oe, 1'b1);
        check("t4_rsp_valid", rsp_valid, 1'b0);
        #1;
        cycle();
        rst = 1'b0;
        wait_init("t4");
        check("t4_ready", req_ready, 1'b1);
        repeat (4) begin
            cycle();
            check("t4_no_stale_rsp", rsp_valid, 1'b0);
        end

        // Sweep range reads (INIT_VAL after the init sweep, pattern otherwise).
        rsp_ready = 1'b1;
        for (int a = 0; a < DD; a++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(a);
            cycle();
        end
        idle();
        repeat (4) cycle();

        // Alternating write/read to one address.
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_addr = 10'd9;
            req_we    = !i[0];
            req_wdata = rand_word();
            cycle();
        end
        idle();
        repeat (4) cycle();

        // Randomized mixed traffic.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 31));
            req_wdata = rand_word();
            rsp_ready = ($urandom_range(0, 9) < 6);
            cycle();
        end
        idle();
        rsp_ready = 1'b1;
        repeat (10) cycle();
        check("final_empty", rsp_valid, 1'b0);
        check("final_ready", req_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
